rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way arbiter with fixed-priority or round-robin selection,
// registered one-hot grant plus binary index, and an optional hold limit
// that forces the owner off the bus after MAX_HOLD consecutive cycles.
// An owner always sits out one IDLE cycle before anyone is granted again.

// Checker: structural properties of the grant outputs.
module rr_arbiter_chk #(
  parameter int N = 4,
  parameter int W = 2
) (
  input logic         clk,
  input logic         rst,
  input logic [N-1:0] gnt,
  input logic [W-1:0] gnt_idx,
  input logic         gnt_valid,
  input logic         expired
);

  // At most one requester is ever granted.
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  // While a grant is held, the one-hot vector and the index agree.
  a_match: assert property (@(posedge clk) disable iff (rst)
    gnt_valid |-> (gnt == (N'(1) << gnt_idx)));

  // With no grant held, the grant vector and the index both read zero.
  a_idle: assert property (@(posedge clk) disable iff (rst)
    !gnt_valid |-> ((gnt == '0) && (gnt_idx == '0)));

  // The expiry pulse only shows up in the idle cycle after a forced release.
  a_exp: assert property (@(posedge clk) disable iff (rst)
    expired |-> !gnt_valid);

endmodule

module rr_arbiter #(
  parameter int  N        = 4,
  parameter int  MODE     = 1,
  parameter int  MAX_HOLD = 8,
  localparam int W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid,
  output logic         expired
);

  // Hold counter only needs to reach MAX_HOLD-1.
  localparam int              HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic            LIM_EN    = (MAX_HOLD != 0);
  localparam logic [W-1:0]    LAST_IDX  = W'(N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [N-1:0]    r_gnt;
  logic [W-1:0]    r_gnt_idx;
  logic            r_gnt_valid;
  logic            r_expired;
  logic [W-1:0]    r_ptr;
  logic [HW-1:0]   r_hold_cnt;

  logic [N-1:0]    w_next_gnt;
  logic [W-1:0]    w_next_gnt_idx;
  logic            w_next_gnt_valid;
  logic            w_next_expired;
  logic [W-1:0]    w_next_ptr;
  logic [HW-1:0]   w_next_hold_cnt;

  logic [W-1:0]    w_winner;
  logic [W-1:0]    w_hi_idx;
  logic            w_hi_found;
  logic [W-1:0]    w_lo_idx;
  logic            w_rel_done;
  logic            w_rel_drop;
  logic            w_rel_lim;
  logic            w_release;

  // One-hot decode of a binary owner index.
  function automatic logic [N-1:0] f_onehot(input logic [W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Winner selection: highest index in fixed mode; in round-robin mode the
  // lowest set bit at or above ptr, else the lowest set bit overall (wrap).
  always_comb begin
    w_winner   = '0;
    w_hi_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_idx   = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        w_winner = req[i] ? W'(i) : w_winner;
      end
    end else begin
      // Descending scans so the last hit is the lowest qualifying index.
      for (int i = N - 1; i >= 0; i--) begin
        w_hi_idx   = (req[i] && (W'(i) >= r_ptr)) ? W'(i) : w_hi_idx;
        w_hi_found = (req[i] && (W'(i) >= r_ptr)) ? 1'b1  : w_hi_found;
        w_lo_idx   = req[i] ? W'(i) : w_lo_idx;
      end
      w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end
  end

  // Release conditions while an owner holds the grant.
  always_comb begin
    w_rel_done = done;
    w_rel_drop = ~req[r_gnt_idx];
    w_rel_lim  = LIM_EN && (r_hold_cnt == HOLD_LAST);
    w_release  = w_rel_done | w_rel_drop | w_rel_lim;
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    w_next_state     = r_state;
    w_next_gnt       = r_gnt;
    w_next_gnt_idx   = r_gnt_idx;
    w_next_gnt_valid = r_gnt_valid;
    w_next_expired   = 1'b0;
    w_next_ptr       = r_ptr;
    w_next_hold_cnt  = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (req != '0) begin
          w_next_state     = S_GRANT;
          w_next_gnt       = f_onehot(w_winner);
          w_next_gnt_idx   = w_winner;
          w_next_gnt_valid = 1'b1;
          w_next_hold_cnt  = '0;
        end else begin
          w_next_state     = S_IDLE;
          w_next_gnt       = '0;
          w_next_gnt_idx   = '0;
          w_next_gnt_valid = 1'b0;
          w_next_hold_cnt  = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_next_state     = S_IDLE;
          w_next_gnt       = '0;
          w_next_gnt_idx   = '0;
          w_next_gnt_valid = 1'b0;
          w_next_hold_cnt  = '0;
          w_next_ptr       = (r_gnt_idx == LAST_IDX) ? '0 : (r_gnt_idx + W'(1));
          // Expiry is reported only when the limit alone forced the release.
          w_next_expired   = w_rel_lim & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_next_hold_cnt  = r_hold_cnt + HW'(1);
        end
      end
      default: begin
        w_next_state     = S_IDLE;
        w_next_gnt       = '0;
        w_next_gnt_idx   = '0;
        w_next_gnt_valid = 1'b0;
        w_next_hold_cnt  = '0;
        w_next_ptr       = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered grant outputs, rotation pointer and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_expired   <= 1'b0;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_gnt       <= w_next_gnt;
      r_gnt_idx   <= w_next_gnt_idx;
      r_gnt_valid <= w_next_gnt_valid;
      r_expired   <= w_next_expired;
      r_ptr       <= w_next_ptr;
      r_hold_cnt  <= w_next_hold_cnt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign expired   = r_expired;

  rr_arbiter_chk #(.N(N), .W(W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .gnt       (r_gnt),
    .gnt_idx   (r_gnt_idx),
    .gnt_valid (r_gnt_valid),
    .expired   (r_expired)
  );

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: three arbiters (round-robin/hold 8, fixed/hold 8,
// round-robin/unlimited) share one stimulus stream. A behavioural model
// tracks owner, cycles held and rotation pointer per instance and is
// compared every cycle; directed scenarios add literal expectations.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       done;
  logic [3:0] req;

  logic [3:0] d_gnt [3];
  logic [1:0] d_idx [3];
  logic       d_val [3];
  logic       d_exp [3];

  int total;
  int bad;

  // Behavioural model state per instance.
  int m_busy  [3];
  int m_owner [3];
  int m_held  [3];
  int m_ptr   [3];
  int m_exp   [3];

  rr_arbiter #(.N(4), .MODE(1), .MAX_HOLD(8)) u_rr (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(d_gnt[0]), .gnt_idx(d_idx[0]), .gnt_valid(d_val[0]), .expired(d_exp[0]));

  rr_arbiter #(.N(4), .MODE(0), .MAX_HOLD(8)) u_fp (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(d_gnt[1]), .gnt_idx(d_idx[1]), .gnt_valid(d_val[1]), .expired(d_exp[1]));

  rr_arbiter #(.N(4), .MODE(1), .MAX_HOLD(0)) u_ul (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(d_gnt[2]), .gnt_idx(d_idx[2]), .gnt_valid(d_val[2]), .expired(d_exp[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int mode_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  function automatic int mh_of(input int k);
    return (k == 2) ? 0 : 8;
  endfunction

  function automatic bit bit_of(input logic [3:0] r, input int i);
    return ((r >> i) & 4'b0001) != 4'b0000;
  endfunction

  // Pick the winner: highest requester, or first requester at/after ptr.
  function automatic int pick(input int mode, input int p, input logic [3:0] r);
    if (mode == 0) begin
      for (int i = 3; i >= 0; i--) if (bit_of(r, i)) return i;
    end else begin
      for (int k = 0; k < 4; k++) if (bit_of(r, (p + k) % 4)) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_update();
    bit drop;
    bit lim;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_owner[k] = 0; m_held[k] = 0; m_ptr[k] = 0; m_exp[k] = 0;
      end else if (m_busy[k] == 0) begin
        m_exp[k] = 0;
        if (req != 4'b0000) begin
          m_owner[k] = pick(mode_of(k), m_ptr[k], req);
          m_busy[k]  = 1;
          m_held[k]  = 1;
        end
      end else begin
        drop = !bit_of(req, m_owner[k]);
        lim  = (mh_of(k) != 0) && (m_held[k] == mh_of(k));
        if (done || drop || lim) begin
          m_exp[k]   = (lim && !done && !drop) ? 1 : 0;
          m_ptr[k]   = (m_owner[k] + 1) % 4;
          m_busy[k]  = 0;
          m_owner[k] = 0;
          m_held[k]  = 0;
        end else begin
          m_held[k]++;
          m_exp[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("gnt[%0d]", k), int'(d_gnt[k]), (m_busy[k] != 0) ? (1 << m_owner[k]) : 0);
      check($sformatf("idx[%0d]", k), int'(d_idx[k]), (m_busy[k] != 0) ? m_owner[k] : 0);
      check($sformatf("valid[%0d]", k), int'(d_val[k]), m_busy[k]);
      check($sformatf("expired[%0d]", k), int'(d_exp[k]), m_exp[k]);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    int exp30 [4];
    exp30 = '{1, 2, 3, 0};
    total = 0;
    bad   = 0;
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_held[k] = 0; m_ptr[k] = 0; m_exp[k] = 0;
    end
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    check("rst_gnt", int'(d_gnt[0]), 0);
    check("rst_valid", int'(d_val[0]), 0);
    check("rst_exp", int'(d_exp[1]), 0);
    rst = 1'b0;

    // Round-robin rotation with done one cycle after each grant.
    req = 4'b1111;
    step();
    check("c30_idx_first", int'(d_idx[0]), 0);
    check("c30_val_first", int'(d_val[0]), 1);
    check("c30_fp_idx", int'(d_idx[1]), 3);
    for (int g = 0; g < 4; g++) begin
      done = 1'b1;
      step();
      check("c30_gap", int'(d_val[0]), 0);
      done = 1'b0;
      step();
      check("c30_val", int'(d_val[0]), 1);
      check("c30_idx", int'(d_idx[0]), exp30[g]);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    step();

    // Fixed priority: highest index wins.
    req = 4'b1010;
    step();
    check("c31_gnt_a", int'(d_gnt[1]), 8);
    check("c31_idx_a", int'(d_idx[1]), 3);
    done = 1'b1;
    req  = 4'b0011;
    step();
    check("c31_gap", int'(d_val[1]), 0);
    done = 1'b0;
    step();
    check("c31_gnt_b", int'(d_gnt[1]), 2);
    check("c31_idx_b", int'(d_idx[1]), 1);
    req = 4'b0000;
    step();
    step();

    // Hold limit: exactly 8 grant cycles then an expiry pulse.
    req = 4'b0001;
    step();
    check("c32_val_1", int'(d_val[0]), 1);
    check("c32_idx", int'(d_idx[0]), 0);
    for (int i = 1; i < 8; i++) begin
      step();
      check("c32_val_hold", int'(d_val[0]), 1);
      check("c32_exp_hold", int'(d_exp[0]), 0);
    end
    step();
    check("c32_val_rel", int'(d_val[0]), 0);
    check("c32_exp_rel", int'(d_exp[0]), 1);
    check("c32_ul_stays", int'(d_val[2]), 1);
    step();
    check("c32_regrant", int'(d_val[0]), 1);
    check("c32_regrant_idx", int'(d_idx[0]), 0);
    check("c32_exp_after", int'(d_exp[0]), 0);
    req = 4'b0000;
    step();
    step();

    // Request drop mid-grant, then wrap from ptr = 3 to index 0.
    req = 4'b0100;
    step();
    check("c33_idx", int'(d_idx[0]), 2);
    req = 4'b0000;
    step();
    check("c33_val_rel", int'(d_val[0]), 0);
    check("c33_exp_rel", int'(d_exp[0]), 0);
    req = 4'b0101;
    step();
    check("c33_wrap_idx", int'(d_idx[0]), 0);
    check("c33_wrap_val", int'(d_val[0]), 1);
    req = 4'b0000;
    step();
    step();

    // Reset during a grant abandons it quietly; arbitration restarts at ptr 0.
    req = 4'b0010;
    step();
    check("c34_idx", int'(d_idx[0]), 1);
    rst = 1'b1;
    req = 4'b0110;
    step();
    check("c34_gnt", int'(d_gnt[0]), 0);
    check("c34_idx_rst", int'(d_idx[0]), 0);
    check("c34_val", int'(d_val[0]), 0);
    check("c34_exp", int'(d_exp[0]), 0);
    rst = 1'b0;
    step();
    check("c34_regrant_idx", int'(d_idx[0]), 1);
    check("c34_regrant_val", int'(d_val[0]), 1);
    req = 4'b0000;
    step();
    step();

    // Unlimited hold: grant stays put for 50 cycles, never expires.
    req = 4'b0100;
    step();
    for (int i = 0; i < 50; i++) begin
      check("c35_gnt", int'(d_gnt[2]), 4);
      check("c35_exp", int'(d_exp[2]), 0);
      step();
    end
    req = 4'b0000;
    step();
    step();

    // Randomized traffic with sticky requests so hold limits get reached.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 11) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
